mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4:1 mux (mux4) among four requesters.
//   It grants one requester at a time and drives the mux select lines so that

---
 rtl/mux4_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 mux.
// One requester holds the mux at a time, for at most MAX_HOLD consecutive
// cycles. All outputs are registered. Winners are visible one cycle after
// the request is sampled.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       new_grant_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_reg, state_next;
    logic [3:0]       grant_reg, grant_next;
    logic [1:0]       sel_reg, sel_next;
    logic             new_grant_reg, new_grant_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [1:0]       last_ptr_reg, last_ptr_next;

    // Candidates for a new grant. While a grant is active the current owner
    // is masked out: if it still requests, a switch only happens at hold
    // expiry, and then the owner must yield to anyone else pending. If it
    // has dropped its request, masking it changes nothing.
    logic [3:0] pick_req;
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       owner_req;

    assign pick_req  = (state_reg == GRANT) ? (req_i & ~grant_reg) : req_i;
    assign owner_req = |(req_i & grant_reg);

    // Search order: last_ptr+1, +2, +3, +4 (the 2-bit sum wraps mod 4).
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand_idx[gi] = last_ptr_reg + 2'(gi + 1);
        assign cand_hit[gi] = pick_req[cand_idx[gi]];
    end

    // Priority pick: the earliest hit in search order wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        sel_next       = sel_reg;
        new_grant_next = 1'b0;
        hold_cnt_next  = hold_cnt_reg;
        last_ptr_next  = last_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next     = GRANT;
                    grant_next     = 4'b0001 << pick_idx;
                    sel_next       = pick_idx;
                    new_grant_next = 1'b1;
                    hold_cnt_next  = '0;
                    last_ptr_next  = pick_idx;
                end
            end
            GRANT: begin
                if (owner_req && (hold_cnt_reg < HOLD_LAST)) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end else if (pick_found) begin
                    // Owner dropped or expired with others waiting: hand over
                    // without an idle bubble.
                    grant_next     = 4'b0001 << pick_idx;
                    sel_next       = pick_idx;
                    new_grant_next = 1'b1;
                    hold_cnt_next  = '0;
                    last_ptr_next  = pick_idx;
                end else if (owner_req) begin
                    // Expired but nobody else wants the mux: keep the same
                    // owner seamlessly, restarting its hold window.
                    hold_cnt_next = '0;
                    last_ptr_next = sel_reg;
                end else begin
                    // Nobody requesting: release; sel stays put so the mux
                    // output does not glitch.
                    state_next = IDLE;
                    grant_next = 4'b0000;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= 4'b0000;
            sel_reg       <= 2'd0;
            new_grant_reg <= 1'b0;
            hold_cnt_reg  <= '0;
            last_ptr_reg  <= 2'd3;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            sel_reg       <= sel_next;
            new_grant_reg <= new_grant_next;
            hold_cnt_reg  <= hold_cnt_next;
            last_ptr_reg  <= last_ptr_next;
        end
    end

    assign grant_o     = grant_reg;
    assign sel_o       = sel_reg;
    assign busy_o      = |grant_reg;
    assign new_grant_o = new_grant_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by
// random request traffic, all compared against a behavioural model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] grant_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       new_grant_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model: who owns the mux, for how many cycles so far,
    // which requester was granted last, and the last mux select.
    int m_owner;
    int m_owned;
    int m_ptr;
    int m_sel;
    bit m_new;

    int pulses;
    int hits;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .sel_o       (sel_o),
        .busy_o      (busy_o),
        .new_grant_o (new_grant_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester in r found walking upward from ptr+1 around the ring,
    // or -1 when r is empty.
    function automatic int rr_search(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [3:0] r, input logic rs);
        logic [3:0] others;
        int w;
        if (rs) begin
            m_owner = -1; m_owned = 0; m_ptr = 3; m_sel = 0; m_new = 0;
            return;
        end
        m_new = 0;
        if (m_owner >= 0 && r[m_owner] && m_owned < MAX_HOLD) begin
            m_owned++;
        end else begin
            others = r;
            if (m_owner >= 0) others[m_owner] = 1'b0;
            w = rr_search(others, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_owned = 1; m_ptr = w; m_new = 1;
            end else if (m_owner >= 0 && r[m_owner]) begin
                m_owned = 1; m_ptr = m_owner;
            end else begin
                m_owner = -1; m_owned = 0;
            end
        end
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic [3:0] r, input logic rs);
        logic [3:0] exp_grant;
        req_i = r;
        rst   = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        check("grant", 8'(grant_o), 8'(exp_grant));
        check("sel", 8'(sel_o), 8'(m_sel));
        check("busy", 8'(busy_o), 8'(m_owner >= 0));
        check("new_grant", 8'(new_grant_o), 8'(m_new));
        $display("t=%0t rst=%b req=%b grant=%b sel=%0d busy=%b new=%b",
                 $time, rs, r, grant_o, sel_o, busy_o, new_grant_o);
    endtask

    initial begin
        rst = 1'b1;
        req_i = 4'b1111;
        m_owner = -1; m_owned = 0; m_ptr = 3; m_sel = 0; m_new = 0;

        // 1: reset with all requests asserted
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        check("t1_grant", 8'(grant_o), 8'h0);
        check("t1_sel", 8'(sel_o), 8'h0);
        check("t1_busy", 8'(busy_o), 8'h0);

        // 2: single request then release, sel must stay
        step(4'b0100, 1'b0);
        check("t2_grant", 8'(grant_o), 8'h4);
        check("t2_sel", 8'(sel_o), 8'h2);
        check("t2_new", 8'(new_grant_o), 8'h1);
        step(4'b0000, 1'b0);
        check("t2_idle_grant", 8'(grant_o), 8'h0);
        check("t2_idle_sel", 8'(sel_o), 8'h2);

        // 3: full contention rotates every MAX_HOLD cycles
        step(4'b1111, 1'b1);
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step(4'b1111, 1'b0);
            if (new_grant_o) pulses++;
            if (i == 4)  check("t3_second_owner", 8'(grant_o), 8'h2);
            if (i == 12) check("t3_fourth_owner", 8'(grant_o), 8'h8);
        end
        check("t3_wrap", 8'(grant_o), 8'h1);
        check("t3_pulses", 8'(pulses), 8'd5);

        // 4: lone requester keeps the mux past hold expiry
        step(4'b0000, 1'b1);
        pulses = 0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0010, 1'b0);
            if (new_grant_o) pulses++;
            if (grant_o == 4'b0010) hits++;
        end
        check("t4_cycles", 8'(hits), 8'd10);
        check("t4_pulses", 8'(pulses), 8'd1);

        // 5: owner 0 drops, requester 3 takes over without a bubble
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b1001, 1'b0);
        step(4'b1000, 1'b0);
        check("t5_grant", 8'(grant_o), 8'h8);
        check("t5_sel", 8'(sel_o), 8'h3);
        check("t5_new", 8'(new_grant_o), 8'h1);
        check("t5_busy", 8'(busy_o), 8'h1);

        // 6: reset mid-grant restores pointer
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        check("t6_rst_grant", 8'(grant_o), 8'h0);
        check("t6_rst_sel", 8'(sel_o), 8'h0);
        step(4'b1111, 1'b0);
        check("t6_after", 8'(grant_o), 8'h1);

        // Random traffic with sticky requests and occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req_i;
            if ($urandom_range(0, 7) == 0) r = r ^ 4'(1 << $urandom_range(0, 3));
            step(r, ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
